// File: rtl/multi_sonar_ranger.sv
// Round-robin ranger for NUM_CH HC-SR04 style sensors: one trigger and one echo-width measurement per fixed slot.
// Latency: echo fall to result_valid is 3 clk (2 sync flops + publish register); timeouts publish at slot end.
// No backpressure: exactly one result per slot, the consumer must take result_valid when it pulses.
module multi_sonar_ranger #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 24,
  parameter int TRIG_PULSE  = 120,
  parameter int SLOT_CYCLES = 750000,
  parameter int NEAR_MIN    = 1,
  parameter int NEAR_MAX    = 14000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       echo,
  output logic [NUM_CH-1:0]       trig,
  output logic                    result_valid,
  output logic [CH_W-1:0]         result_ch,
  output logic [WIDTH-1:0]        result_width,
  output logic                    result_timeout,
  output logic [NUM_CH*WIDTH-1:0] echo_cycles,
  output logic [NUM_CH-1:0]       present
);

  localparam int SLOT_W = $clog2(SLOT_CYCLES + 1);
  localparam int XW     = WIDTH + 32;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] TRIG_LAST  = SLOT_W'(TRIG_PULSE - 1);
  localparam logic [XW-1:0]     NEAR_MIN_X = XW'(NEAR_MIN);
  localparam logic [XW-1:0]     NEAR_MAX_X = XW'(NEAR_MAX);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t             state, state_nxt;
  logic [NUM_CH-1:0]  echo_m, echo_s;
  logic [SLOT_W-1:0]  slot_cnt;
  logic [CH_W-1:0]    active, active_nxt;
  logic [WIDTH-1:0]   width, width_inc, pub_width;
  logic [NUM_CH-1:0]  trig_nxt;
  logic               echo_act, slot_end, pub, pub_to, pub_present;

  assign echo_act  = echo_s[active];
  assign slot_end  = (state != IDLE) && (slot_cnt == SLOT_LAST);
  // Saturate instead of wrapping so a stuck echo reads as "very far", never as a short range.
  assign width_inc = (&width) ? width : width + 1'b1;
  assign pub_present = !pub_to && (XW'(pub_width) >= NEAR_MIN_X) && (XW'(pub_width) <= NEAR_MAX_X);

  // Two-flop synchronizer for the asynchronous echo lines
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_m <= '0;
      echo_s <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and next active channel; slot end overrides whatever the echo is doing
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    case (state)
      IDLE:      if (en) state_nxt = TRIG;
      TRIG:      if (slot_cnt == TRIG_LAST) state_nxt = WAIT_RISE;
      WAIT_RISE: if (echo_act) state_nxt = MEASURE;
      MEASURE:   if (!echo_act) state_nxt = HOLDOFF;
      HOLDOFF:   state_nxt = HOLDOFF;
      default:   state_nxt = IDLE;
    endcase
    if (slot_end) begin
      state_nxt  = en ? TRIG : IDLE;
      active_nxt = (!en || active == LAST_CH) ? '0 : active + 1'b1;
    end
  end

  // Publish decision and trigger pattern for the coming cycle
  always_comb begin
    pub       = 1'b0;
    pub_to    = 1'b0;
    pub_width = width;
    trig_nxt  = (state_nxt == TRIG) ? (NUM_CH'(1) << active_nxt) : '0;
    case (state)
      WAIT_RISE: begin
        // A rise seen on the very last cycle cannot be measured inside the slot.
        if (slot_end) begin
          pub       = 1'b1;
          pub_to    = 1'b1;
          pub_width = '0;
        end
      end
      MEASURE: begin
        if (!echo_act) begin
          pub = 1'b1;
        end else if (slot_end) begin
          pub       = 1'b1;
          pub_to    = 1'b1;
          pub_width = width_inc;
        end
      end
      default: pub = 1'b0;
    endcase
  end

  // Slot timing, active channel and echo width counter
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      active   <= '0;
      width    <= '0;
    end else begin
      slot_cnt <= (slot_end || state == IDLE) ? '0 : slot_cnt + 1'b1;
      active   <= active_nxt;
      case (state)
        TRIG:      width <= '0;
        WAIT_RISE: if (echo_act) width <= WIDTH'(1);
        MEASURE:   if (echo_act) width <= width_inc;
        default:   width <= width;
      endcase
    end
  end

  // Registered trigger and result outputs, per-channel history updated on publish
  always_ff @(posedge clk) begin
    if (reset) begin
      trig           <= '0;
      result_valid   <= 1'b0;
      result_ch      <= '0;
      result_width   <= '0;
      result_timeout <= 1'b0;
      echo_cycles    <= '0;
      present        <= '0;
    end else begin
      trig         <= trig_nxt;
      result_valid <= pub;
      if (pub) begin
        result_ch      <= active;
        result_width   <= pub_width;
        result_timeout <= pub_to;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (pub && active == CH_W'(c)) begin
          echo_cycles[c*WIDTH +: WIDTH] <= pub_width;
          present[c]                    <= pub_present;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_sonar_ranger.sv
module tb_multi_sonar_ranger;
  localparam int NUM_CH = 2;
  localparam int WIDTH  = 8;
  localparam int TP     = 4;
  localparam int S      = 400;
  localparam int NMIN   = 1;
  localparam int NMAX   = 20;
  localparam int MAXW   = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic reset, en;
  logic [NUM_CH-1:0] echo, trig, present;
  logic result_valid, result_timeout;
  logic [0:0] result_ch;
  logic [WIDTH-1:0] result_width;
  logic [NUM_CH*WIDTH-1:0] echo_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_sonar_ranger #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TRIG_PULSE(TP), .SLOT_CYCLES(S),
                       .NEAR_MIN(NMIN), .NEAR_MAX(NMAX)) dut (
    .clk(clk), .reset(reset), .en(en), .echo(echo), .trig(trig),
    .result_valid(result_valid), .result_ch(result_ch), .result_width(result_width),
    .result_timeout(result_timeout), .echo_cycles(echo_cycles), .present(present));

  typedef struct {int cyc; int ch; int w; int to;} res_t;
  typedef struct {bit seen; int t; int ch; int tlen; int nres; int rcyc; int rch; int rw; int rto;} obs_t;

  // Monitor: samples 1 time unit after each rising edge
  int cyc = 0, rise_cnt = 0, rise_cyc = -1, rise_ch = -1, fall_cyc = -1, multi_trig = 0;
  logic [NUM_CH-1:0] trig_q = '0;
  res_t res_q[$];

  always @(posedge clk) begin : mon
    res_t r;
    #1;
    cyc++;
    if ($countones(trig) > 1) multi_trig++;
    if (trig != '0 && trig_q == '0) begin
      rise_cnt++;
      rise_cyc = cyc;
      for (int k = 0; k < NUM_CH; k++) if (trig[k]) rise_ch = k;
    end
    if (trig == '0 && trig_q != '0) fall_cyc = cyc;
    trig_q = trig;
    if (result_valid) begin
      r.cyc = cyc; r.ch = int'(result_ch); r.w = int'(result_width); r.to = int'(result_timeout);
      res_q.push_back(r);
    end
  end

  // Reference model state
  int consumed = 0, prev_t = -1, exp_ch = 0;
  int exp_ec[NUM_CH];
  bit exp_pr[NUM_CH];

  // Expected result of a slot whose active echo is driven high for slot-relative cycles [st, st+len).
  // The synchronizer shifts it to [st+2, st+len+1]; only samples from the end of the trigger count.
  function automatic void model(input int st, input int len, output int w, output int to, output int vis);
    int s, e, rise, cnt;
    w = 0; to = 1; vis = S;
    if (len > 0) begin
      s = st + 2;
      e = st + len + 1;
      rise = (s > TP) ? s : TP;
      if (e >= TP && rise < S - 1) begin
        if (e < S - 1) begin
          cnt = e - rise + 1; to = 0; vis = e + 2;
        end else begin
          cnt = S - rise;
        end
        w = (cnt > MAXW) ? MAXW : cnt;
      end
    end
  endfunction

  task automatic note(input int ch, input int w, input int to);
    exp_ec[ch] = w;
    exp_pr[ch] = (to == 0) && (w >= NMIN) && (w <= NMAX);
    exp_ch = (ch + 1) % NUM_CH;
  endtask

  // Waits for the next slot, drives the echoes through it and collects what it produced
  task automatic run_slot(input int st, input int len, input int ost, input int olen,
                          input int drop_at, output obs_t o);
    int guard = 0;
    int i;
    res_t r;
    o.seen = 0; o.t = 0; o.ch = -1; o.tlen = -1; o.nres = 0; o.rcyc = -1; o.rch = -1; o.rw = -1; o.rto = -1;
    while (rise_cnt <= consumed && guard < 3 * S) begin @(negedge clk); guard++; end
    if (rise_cnt <= consumed) return;
    o.seen = 1; consumed = rise_cnt; o.t = rise_cyc; o.ch = rise_ch;
    while (cyc < o.t + S) begin
      i = cyc - o.t;
      echo = '0;
      if (len > 0 && i >= st && i < st + len) echo[o.ch] = 1'b1;
      if (olen > 0 && i >= ost && i < ost + olen) echo[(o.ch + 1) % NUM_CH] = 1'b1;
      if (i == drop_at) en = 1'b0;
      @(negedge clk);
    end
    echo = '0;
    o.tlen = fall_cyc - o.t;
    while (res_q.size() > 0) begin
      r = res_q.pop_front();
      if (r.cyc > o.t && r.cyc <= o.t + S) begin
        o.nres++; o.rcyc = r.cyc - o.t; o.rch = r.ch; o.rw = r.w; o.rto = r.to;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; echo = '0;
    for (int k = 0; k < NUM_CH; k++) begin exp_ec[k] = 0; exp_pr[k] = 0; end
    repeat (3) @(negedge clk);
    n_cmp++; if (trig !== '0) begin n_bad++; $display("FAIL rst_trig: got %0h want 0", trig); end
    n_cmp++; if (result_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %0b want 0", result_valid); end
    n_cmp++; if (result_ch !== '0) begin n_bad++; $display("FAIL rst_ch: got %0d want 0", result_ch); end
    n_cmp++; if (result_width !== '0) begin n_bad++; $display("FAIL rst_width: got %0d want 0", result_width); end
    n_cmp++; if (result_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %0b want 0", result_timeout); end
    n_cmp++; if (echo_cycles !== '0) begin n_bad++; $display("FAIL rst_echo_cycles: got %0h want 0", echo_cycles); end
    n_cmp++; if (present !== '0) begin n_bad++; $display("FAIL rst_present: got %0b want 0", present); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (trig !== '0) begin n_bad++; $display("FAIL idle_trig: got %0h want 0", trig); end
  endtask

  task automatic test_basic;
    obs_t o;
    int t_en, w, to, vis;
    en = 1'b1; t_en = cyc;
    run_slot(TP + 5, 10, 0, 0, -1, o);
    model(TP + 5, 10, w, to, vis);
    note(0, w, to);
    n_cmp++; if (!o.seen) begin n_bad++; $display("FAIL basic_start: got no trig want trig"); end
    n_cmp++; if (o.t !== t_en + 1) begin n_bad++; $display("FAIL basic_trig_cycle: got %0d want %0d", o.t, t_en + 1); end
    n_cmp++; if (o.ch !== 0) begin n_bad++; $display("FAIL basic_trig_ch: got %0d want 0", o.ch); end
    n_cmp++; if (o.tlen !== TP) begin n_bad++; $display("FAIL basic_trig_len: got %0d want %0d", o.tlen, TP); end
    n_cmp++; if (o.nres !== 1) begin n_bad++; $display("FAIL basic_nres: got %0d want 1", o.nres); end
    n_cmp++; if (o.rch !== 0) begin n_bad++; $display("FAIL basic_rch: got %0d want 0", o.rch); end
    n_cmp++; if (o.rw !== 10) begin n_bad++; $display("FAIL basic_width: got %0d want 10", o.rw); end
    n_cmp++; if (o.rto !== 0) begin n_bad++; $display("FAIL basic_timeout: got %0d want 0", o.rto); end
    n_cmp++; if (o.rcyc !== TP + 5 + 10 + 3) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", o.rcyc, TP + 18); end
    n_cmp++; if (present[0] !== 1'b1) begin n_bad++; $display("FAIL basic_present: got %0b want 1", present[0]); end
    n_cmp++; if (echo_cycles[7:0] !== 8'd10) begin n_bad++; $display("FAIL basic_echo_cycles: got %0d want 10", echo_cycles[7:0]); end
    prev_t = o.t;
  endtask

  task automatic test_ch1;
    obs_t o;
    int st;
    st = TP + int'($urandom_range(0, 50));
    run_slot(st, 30, 0, 0, -1, o);
    note(1, 30, 0);
    n_cmp++; if (o.ch !== 1) begin n_bad++; $display("FAIL ch1_trig_ch: got %0d want 1", o.ch); end
    n_cmp++; if (o.t - prev_t !== S) begin n_bad++; $display("FAIL ch1_spacing: got %0d want %0d", o.t - prev_t, S); end
    n_cmp++; if (o.rch !== 1 || o.rw !== 30 || o.rto !== 0) begin n_bad++;
      $display("FAIL ch1_result: got ch%0d w%0d to%0d want ch1 w30 to0", o.rch, o.rw, o.rto); end
    n_cmp++; if (present !== 2'b01) begin n_bad++; $display("FAIL ch1_present: got %b want 01", present); end
    n_cmp++; if (echo_cycles[15:8] !== 8'd30) begin n_bad++; $display("FAIL ch1_echo_cycles: got %0d want 30", echo_cycles[15:8]); end
    prev_t = o.t;
  endtask

  task automatic test_no_echo;
    obs_t o;
    run_slot(0, 0, 0, 0, -1, o);
    note(0, 0, 1);
    n_cmp++; if (o.ch !== 0 || o.t - prev_t !== S) begin n_bad++; $display("FAIL noecho_trig: got ch%0d gap%0d want ch0 gap%0d", o.ch, o.t - prev_t, S); end
    n_cmp++; if (o.nres !== 1) begin n_bad++; $display("FAIL noecho_nres: got %0d want 1", o.nres); end
    n_cmp++; if (o.rch !== 0 || o.rw !== 0 || o.rto !== 1) begin n_bad++;
      $display("FAIL noecho_result: got ch%0d w%0d to%0d want ch0 w0 to1", o.rch, o.rw, o.rto); end
    n_cmp++; if (o.rcyc !== S) begin n_bad++; $display("FAIL noecho_when: got %0d want %0d", o.rcyc, S); end
    n_cmp++; if (present[0] !== 1'b0 || echo_cycles[7:0] !== 8'd0) begin n_bad++;
      $display("FAIL noecho_state: got p%0b ec%0d want p0 ec0", present[0], echo_cycles[7:0]); end
    prev_t = o.t;
  endtask

  task automatic test_stuck;
    obs_t o;
    run_slot(0, S, 0, 0, -1, o);
    note(1, MAXW, 1);
    n_cmp++; if (o.ch !== 1 || o.nres !== 1) begin n_bad++; $display("FAIL stuck_slot: got ch%0d n%0d want ch1 n1", o.ch, o.nres); end
    n_cmp++; if (o.rw !== MAXW || o.rto !== 1) begin n_bad++; $display("FAIL stuck_result: got w%0d to%0d want w%0d to1", o.rw, o.rto, MAXW); end
    n_cmp++; if (o.rcyc !== S) begin n_bad++; $display("FAIL stuck_when: got %0d want %0d", o.rcyc, S); end
    n_cmp++; if (echo_cycles[15:8] !== 8'd255 || present[1] !== 1'b0) begin n_bad++;
      $display("FAIL stuck_state: got ec%0d p%0b want ec255 p0", echo_cycles[15:8], present[1]); end
    prev_t = o.t;
  endtask

  task automatic test_crosstalk;
    obs_t o;
    int st, len, w, to, vis;
    st = TP + 3 + int'($urandom_range(0, 20)); len = int'($urandom_range(1, 15));
    run_slot(st, len, TP, 200, -1, o);
    model(st, len, w, to, vis);
    note(0, w, to);
    n_cmp++; if (o.ch !== 0 || o.t - prev_t !== S) begin n_bad++; $display("FAIL xtalk_trig: got ch%0d gap%0d want ch0 gap%0d", o.ch, o.t - prev_t, S); end
    n_cmp++; if (o.nres !== 1 || o.rw !== w || o.rto !== to) begin n_bad++;
      $display("FAIL xtalk_result: got n%0d w%0d to%0d want n1 w%0d to%0d", o.nres, o.rw, o.rto, w, to); end
    n_cmp++; if (echo_cycles[15:8] !== 8'd255) begin n_bad++; $display("FAIL xtalk_ch1_kept: got %0d want 255", echo_cycles[15:8]); end
    n_cmp++; if (present[0] !== exp_pr[0]) begin n_bad++; $display("FAIL xtalk_present: got %0b want %0b", present[0], exp_pr[0]); end
    prev_t = o.t;
  endtask

  task automatic test_random;
    obs_t o;
    int st, len, w, to, vis, ch;
    for (int n = 0; n < 5; n++) begin
      st = int'($urandom_range(0, S - 1)); len = int'($urandom_range(1, 320));
      ch = exp_ch;
      run_slot(st, len, int'($urandom_range(0, S - 1)), int'($urandom_range(0, 300)), -1, o);
      model(st, len, w, to, vis);
      note(ch, w, to);
      n_cmp++; if (o.ch !== ch || o.t - prev_t !== S) begin n_bad++;
        $display("FAIL rand%0d_trig: got ch%0d gap%0d want ch%0d gap%0d", n, o.ch, o.t - prev_t, ch, S); end
      n_cmp++; if (o.nres !== 1 || o.rch !== ch || o.rw !== w || o.rto !== to || o.rcyc !== vis) begin n_bad++;
        $display("FAIL rand%0d_result (st%0d len%0d): got n%0d ch%0d w%0d to%0d at%0d want n1 ch%0d w%0d to%0d at%0d",
                 n, st, len, o.nres, o.rch, o.rw, o.rto, o.rcyc, ch, w, to, vis); end
      for (int k = 0; k < NUM_CH; k++) begin
        n_cmp++; if (int'(echo_cycles[k*WIDTH +: WIDTH]) !== exp_ec[k] || present[k] !== exp_pr[k]) begin n_bad++;
          $display("FAIL rand%0d_state%0d: got ec%0d p%0b want ec%0d p%0b", n, k, echo_cycles[k*WIDTH +: WIDTH], present[k], exp_ec[k], exp_pr[k]); end
      end
      prev_t = o.t;
    end
    n_cmp++; if (multi_trig !== 0) begin n_bad++; $display("FAIL trig_onehot: got %0d multi-hot cycles want 0", multi_trig); end
  endtask

  task automatic test_en_drop;
    obs_t o;
    int rc;
    run_slot(TP + 5, 8, 0, 0, TP + 20, o);
    note(0, 8, 0);
    exp_ch = 0;
    n_cmp++; if (o.ch !== 0 || o.nres !== 1 || o.rw !== 8 || o.rto !== 0) begin n_bad++;
      $display("FAIL endrop_result: got ch%0d n%0d w%0d to%0d want ch0 n1 w8 to0", o.ch, o.nres, o.rw, o.rto); end
    rc = rise_cnt;
    repeat (2 * S) @(negedge clk);
    n_cmp++; if (rise_cnt !== rc || trig !== '0) begin n_bad++;
      $display("FAIL endrop_idle: got %0d new trigs trig=%0h want 0 new trigs", rise_cnt - rc, trig); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    int t_en, guard, w, to, vis;
    en = 1'b1; t_en = cyc; guard = 0;
    while (rise_cnt <= consumed && guard < 2 * S) begin @(negedge clk); guard++; end
    consumed = rise_cnt;
    n_cmp++; if (rise_ch !== 0 || rise_cyc !== t_en + 1) begin n_bad++;
      $display("FAIL restart_ch: got ch%0d at %0d want ch0 at %0d", rise_ch, rise_cyc, t_en + 1); end
    while (cyc < rise_cyc + TP + 2) @(negedge clk);
    echo[0] = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1; en = 1'b0;
    @(negedge clk);
    n_cmp++; if (trig !== '0 || result_valid !== 1'b0 || result_ch !== '0 || result_width !== '0 || result_timeout !== 1'b0
                 || echo_cycles !== '0 || present !== '0) begin n_bad++;
      $display("FAIL midreset_outputs: got trig%0h v%0b ch%0d w%0d to%0b ec%0h p%0b want all 0",
               trig, result_valid, result_ch, result_width, result_timeout, echo_cycles, present); end
    echo = '0; reset = 1'b0; en = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin exp_ec[k] = 0; exp_pr[k] = 0; end
    @(negedge clk);
    consumed = rise_cnt;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (trig !== '0) begin n_bad++; $display("FAIL trig_reset_drop: got %0h want 0", trig); end
    reset = 1'b0; en = 1'b1; t_en = cyc;
    run_slot(TP + 7, 12, 0, 0, -1, o);
    model(TP + 7, 12, w, to, vis);
    n_cmp++; if (o.ch !== 0 || o.t !== t_en + 1) begin n_bad++;
      $display("FAIL restart2_trig: got ch%0d at %0d want ch0 at %0d", o.ch, o.t, t_en + 1); end
    n_cmp++; if (o.nres !== 1 || o.rw !== w || o.rto !== to || int'(echo_cycles[7:0]) !== w || present[0] !== 1'b1) begin n_bad++;
      $display("FAIL restart2_result: got n%0d w%0d to%0d ec%0d p%0b want n1 w%0d to%0d p1", o.nres, o.rw, o.rto, echo_cycles[7:0], present[0], w, to); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; echo = '0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_ch1;
    test_no_echo;
    test_stuck;
    test_crosstalk;
    test_random;
    test_en_drop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
